decode_stage: RTL

Instruction-decode stage of the pipelined MIPS-subset core; sits directly upstream of the 32×32 register file and its execute-stage consumer. Accepts instructions from fetch over a valid/ready handshake and decodes the fields. Drives the register file read port (dir_a, dir_b, reg_rd) and issues a registered ID/EX bundle aligned with the file's one-cycle read latency. A 31-entry scoreboard stalls on RAW/WAW hazards until writeback retires the producer.

---
 rtl/decode_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// decode_stage: MIPS-subset instruction decode with a one-entry holding
// register, a register-file read port, a scoreboard for RAW/WAW hazard
// stalls, and a registered ID/EX bundle.
// Optional build macro DECODE_PERF_EN adds a hazard-stall cycle counter;
// without it stall_cnt is tied to zero.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  output logic        if_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_dir,
  output logic [4:0]  dir_a,
  output logic [4:0]  dir_b,
  output logic        reg_rd,
  output logic        ex_valid,
  output logic [5:0]  ex_op,
  output logic [5:0]  ex_funct,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_imm,
  output logic        ex_wr,
  output logic        ex_mem_rd,
  output logic        ex_mem_wr,
  output logic        ex_ill,
  output logic [31:0] stall_cnt
);

  logic [31:0] inst_q;
  logic        inst_v;
  // bit 0 exists only so any 5-bit address indexes cleanly; r0 never gets set
  logic [31:0] busy;
  logic [31:0] busy_nxt;

  logic [5:0]  op;
  logic [4:0]  rs, rt;
  logic        use_a, use_b, mrd, mwr, ill, wr;
  logic [4:0]  dst;
  logic [5:0]  funct;
  logic [31:0] imm;
  logic        blk_a, blk_b, blk_d, hazard, issue;

  assign op = inst_q[31:26];
  assign rs = inst_q[25:21];
  assign rt = inst_q[20:16];

  // field decode of the held instruction
  always_comb begin
    use_a = 1'b0;
    use_b = 1'b0;
    dst   = 5'd0;
    funct = 6'd0;
    imm   = 32'd0;
    mrd   = 1'b0;
    mwr   = 1'b0;
    ill   = 1'b0;
    case (op)
      6'h00: begin
        use_a = 1'b1; use_b = 1'b1;
        dst   = inst_q[15:11];
        funct = inst_q[5:0];
      end
      6'h08, 6'h0A: begin
        use_a = 1'b1; dst = rt;
        imm   = {{16{inst_q[15]}}, inst_q[15:0]};
      end
      6'h0C, 6'h0D: begin
        use_a = 1'b1; dst = rt;
        imm   = {16'h0000, inst_q[15:0]};
      end
      6'h23: begin
        use_a = 1'b1; dst = rt; mrd = 1'b1;
        imm   = {{16{inst_q[15]}}, inst_q[15:0]};
      end
      6'h2B: begin
        use_a = 1'b1; use_b = 1'b1; mwr = 1'b1;
        imm   = {{16{inst_q[15]}}, inst_q[15:0]};
      end
      6'h04: begin
        use_a = 1'b1; use_b = 1'b1;
        imm   = {{16{inst_q[15]}}, inst_q[15:0]};
      end
      default: ill = 1'b1;
    endcase
  end

  // a zero destination means no register write at all
  assign wr = (dst != 5'd0);

  // same-cycle writeback bypasses a source block; WAW has no bypass
  assign blk_a  = use_a && busy[rs] && !(wb_valid && wb_dir == rs);
  assign blk_b  = use_b && busy[rt] && !(wb_valid && wb_dir == rt);
  assign blk_d  = wr && busy[dst];
  assign hazard = blk_a || blk_b || blk_d;
  assign issue  = inst_v && !hazard;

  assign if_ready = !inst_v || issue;
  assign dir_a    = inst_v ? rs : 5'd0;
  assign dir_b    = inst_v ? rt : 5'd0;
  assign reg_rd   = inst_v && (use_a || use_b);

  // scoreboard update: clear on writeback, then set on issue so set wins
  always_comb begin
    busy_nxt = busy;
    if (wb_valid) busy_nxt[wb_dir] = 1'b0;
    if (issue && wr) busy_nxt[dst] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // holding register and scoreboard state
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_v <= 1'b0;
      inst_q <= 32'd0;
      busy   <= 32'd0;
    end else begin
      busy <= busy_nxt;
      if (if_valid && if_ready) begin
        inst_v <= 1'b1;
        inst_q <= if_instr;
      end else if (issue) begin
        inst_v <= 1'b0;
      end
    end
  end

  // ID/EX bundle: loaded on issue, zeroed as a bubble otherwise. Illegal
  // opcodes issue with ex_valid=1 and ex_ill=1 so the flag is qualified.
  always_ff @(posedge clk) begin
    if (rst || !issue) begin
      ex_valid  <= 1'b0;
      ex_op     <= 6'd0;
      ex_funct  <= 6'd0;
      ex_rd     <= 5'd0;
      ex_imm    <= 32'd0;
      ex_wr     <= 1'b0;
      ex_mem_rd <= 1'b0;
      ex_mem_wr <= 1'b0;
      ex_ill    <= 1'b0;
    end else begin
      ex_valid  <= 1'b1;
      ex_op     <= op;
      ex_funct  <= funct;
      ex_rd     <= dst;
      ex_imm    <= imm;
      ex_wr     <= wr;
      ex_mem_rd <= mrd;
      ex_mem_wr <= mwr;
      ex_ill    <= ill;
    end
  end

`ifdef DECODE_PERF_EN
  logic [31:0] stall_q;
  // count every cycle a held instruction is blocked by a hazard
  always_ff @(posedge clk) begin
    if (rst) stall_q <= 32'd0;
    else if (inst_v && hazard) stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
